// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg -- rw flag and FSM state encodings shared by the arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_RESP = 2'b10,
        RESP      = 2'b11
    } arb_state_e;

    // 2'b11 (both bits set) is treated as idle, same as 2'b00.
    function automatic logic rw_is_valid(input logic [1:0] flag);
        return (flag != RW_IDLE) && (flag != (RW_READ | RW_WRITE));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ============================================================================
// mem_arb_rr -- combinational 2-way round-robin picker.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arb_rr (
    input  logic [1:0] i_eligible,
    input  logic       i_last_grant,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    always_comb begin
        o_grant_valid = |i_eligible;
        // On a tie the channel that did not win last time goes first.
        if (&i_eligible) begin
            o_grant_id = ~i_last_grant;
        end else begin
            o_grant_id = i_eligible[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter -- serialises two CPU memory channels onto one req/gnt/rvalid RAM.
// Optional statistics counters enabled by MEM_ARB_STAT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            cpu_rwe_i,
    input  logic [2*ADDR_W-1:0]   cpu_addr_i,
    input  logic [7:0]            cpu_sel_i,
    input  logic [2*DATA_W-1:0]   cpu_wdata_i,
    output logic [2*DATA_W-1:0]   cpu_rdata_o,
    output logic [1:0]            cpu_busy_o,
    output logic [1:0]            cpu_done_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    output logic [3:0]            ram_sel_o,
    input  logic                  ram_gnt_i,
    input  logic                  ram_rvalid_i,
    input  logic [DATA_W-1:0]     ram_rdata_i
`ifdef MEM_ARB_STAT_EN
    ,
    output logic [63:0]           stat_req_cnt_o,
    output logic [63:0]           stat_wait_cnt_o
`endif
);

    arb_state_e               r_state;
    logic                     r_last_grant;
    logic                     r_owner;
    logic                     r_we;
    logic                     r_req;
    logic [ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic [3:0]               r_sel;
    logic [1:0]               r_busy;
    logic [1:0]               r_done;
    logic [1:0][DATA_W-1:0]   r_rdata;

    logic [1:0]               w_eligible;
    logic                     w_grant_valid;
    logic                     w_grant_id;
    logic [1:0]               w_flag;
    logic [ADDR_W-1:0]        w_addr;
    logic [DATA_W-1:0]        w_wdata;
    logic [3:0]               w_sel;

    // A channel in its done cycle is excluded so the same request is not re-taken.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            w_eligible[c] = rw_is_valid(cpu_rwe_i[2*c +: 2]) && !r_busy[c] && !r_done[c];
        end
    end

    mem_arb_rr u_rr (
        .i_eligible    (w_eligible),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    always_comb begin
        if (w_grant_id) begin
            w_flag  = cpu_rwe_i[3:2];
            w_addr  = cpu_addr_i[2*ADDR_W-1:ADDR_W];
            w_wdata = cpu_wdata_i[2*DATA_W-1:DATA_W];
            w_sel   = cpu_sel_i[7:4];
        end else begin
            w_flag  = cpu_rwe_i[1:0];
            w_addr  = cpu_addr_i[ADDR_W-1:0];
            w_wdata = cpu_wdata_i[DATA_W-1:0];
            w_sel   = cpu_sel_i[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_sel        <= '0;
            r_busy       <= '0;
            r_done       <= '0;
            r_rdata      <= '0;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner           <= w_grant_id;
                        r_last_grant      <= w_grant_id;
                        r_we              <= (w_flag == RW_WRITE);
                        r_addr            <= w_addr;
                        r_wdata           <= w_wdata;
                        r_sel             <= (w_flag == RW_WRITE) ? w_sel : 4'hF;
                        r_busy[w_grant_id] <= 1'b1;
                        r_req             <= 1'b1;
                        r_state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ram_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (ram_rvalid_i) begin
                        if (!r_we) begin
                            r_rdata[r_owner] <= ram_rdata_i;
                        end
                        r_busy[r_owner] <= 1'b0;
                        r_done[r_owner] <= 1'b1;
                        r_state         <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata_o = r_rdata;
    assign cpu_busy_o  = r_busy;
    assign cpu_done_o  = r_done;
    assign ram_req_o   = r_req;
    assign ram_we_o    = r_we;
    assign ram_addr_o  = r_addr;
    assign ram_wdata_o = r_wdata;
    assign ram_sel_o   = r_sel;

`ifdef MEM_ARB_STAT_EN
    logic [1:0][31:0] r_req_cnt;
    logic [1:0][31:0] r_wait_cnt;

    // Waiting means a valid flag that is neither busy nor in its done cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if ((r_state == IDLE) && w_grant_valid && (int'(w_grant_id) == c)) begin
                    r_req_cnt[c] <= r_req_cnt[c] + 32'd1;
                end
                if (w_eligible[c]) begin
                    r_wait_cnt[c] <= r_wait_cnt[c] + 32'd1;
                end
            end
        end
    end

    assign stat_req_cnt_o  = r_req_cnt;
    assign stat_wait_cnt_o = r_wait_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter -- directed scenarios plus random traffic against a
// transaction-level reference model of the arbiter.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cpu_rwe_i;
    logic [63:0] cpu_addr_i;
    logic [7:0]  cpu_sel_i;
    logic [63:0] cpu_wdata_i;
    logic [63:0] cpu_rdata_o;
    logic [1:0]  cpu_busy_o;
    logic [1:0]  cpu_done_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_sel_o;
    logic        ram_gnt_i;
    logic        ram_rvalid_i;
    logic [31:0] ram_rdata_i;
`ifdef MEM_ARB_STAT_EN
    logic [63:0] stat_req_cnt_o;
    logic [63:0] stat_wait_cnt_o;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_rwe_i    (cpu_rwe_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_sel_i    (cpu_sel_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_busy_o   (cpu_busy_o),
        .cpu_done_o   (cpu_done_o),
        .ram_req_o    (ram_req_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_sel_o    (ram_sel_o),
        .ram_gnt_i    (ram_gnt_i),
        .ram_rvalid_i (ram_rvalid_i),
        .ram_rdata_i  (ram_rdata_i)
`ifdef MEM_ARB_STAT_EN
        ,
        .stat_req_cnt_o  (stat_req_cnt_o),
        .stat_wait_cnt_o (stat_wait_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- word memories (reference and RAM responder) ----------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rd_ram(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
    endfunction

    // ---------------- reference model: one in-flight transaction ------------
    bit          m_act, m_gseen, m_we;
    int          m_own, m_last;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_sel;
    logic [1:0]  m_dpulse;
    logic [31:0] m_rdata [2];

    task automatic model_reset();
        m_act = 0; m_gseen = 0; m_we = 0; m_own = 0; m_last = 1;
        m_addr = 0; m_wdata = 0; m_sel = 0; m_dpulse = 0;
        m_rdata[0] = 0; m_rdata[1] = 0;
    endtask

    task automatic model_step();
        logic [1:0] nd;
        logic [1:0] el;
        logic [1:0] f;
        int pick;
        nd = 2'b00;
        if (m_act) begin
            if (!m_gseen) begin
                if (ram_gnt_i) m_gseen = 1;
            end else if (ram_rvalid_i) begin
                if (m_we) ref_mem[m_addr] = merge(rd_ref(m_addr), m_wdata, m_sel);
                else      m_rdata[m_own] = rd_ref(m_addr);
                nd[m_own] = 1'b1;
                m_act = 0;
            end
        end else if (m_dpulse == 2'b00) begin
            for (int c = 0; c < 2; c++) begin
                f = cpu_rwe_i[2*c +: 2];
                el[c] = (f == 2'b01) || (f == 2'b10);
            end
            if (el != 2'b00) begin
                if (el == 2'b11) pick = (m_last == 0) ? 1 : 0;
                else             pick = el[1] ? 1 : 0;
                m_act   = 1; m_gseen = 0; m_own = pick; m_last = pick;
                m_we    = (cpu_rwe_i[2*pick +: 2] == 2'b10);
                m_addr  = cpu_addr_i[32*pick +: 32];
                m_wdata = cpu_wdata_i[32*pick +: 32];
                m_sel   = cpu_sel_i[4*pick +: 4];
            end
        end
        m_dpulse = nd;
    endtask

    task automatic check_model();
        logic [1:0] eb;
        eb = 2'b00;
        if (m_act) eb[m_own] = 1'b1;
        chk("req",   ram_req_o,   m_act && !m_gseen);
        chk("busy",  cpu_busy_o,  eb);
        chk("done",  cpu_done_o,  m_dpulse);
        chk("rdata", cpu_rdata_o, {m_rdata[1], m_rdata[0]});
        if (m_act && !m_gseen) begin
            chk("we",   ram_we_o,   m_we);
            chk("addr", ram_addr_o, m_addr);
            chk("sel",  ram_sel_o,  m_we ? m_sel : 4'hF);
            if (m_we) chk("wdata", ram_wdata_o, m_wdata);
        end
    endtask

    // ---------------- RAM responder ----------------------------------------
    bit          rand_mode, spur_en, r_out, c_we;
    int          g_delay, r_delay, gcnt, rcnt;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_sel;

    function automatic int next_gdelay();
        return rand_mode ? int'($urandom_range(0, 3)) : g_delay;
    endfunction

    function automatic int next_rdelay();
        return rand_mode ? int'($urandom_range(1, 4)) : r_delay;
    endfunction

    task automatic ram_reset();
        ram_gnt_i = 0; ram_rvalid_i = 0; ram_rdata_i = 0;
        r_out = 0; gcnt = next_gdelay();
    endtask

    task automatic ram_drive();
        ram_gnt_i = 0; ram_rvalid_i = 0; ram_rdata_i = $urandom;
        if (r_out) begin
            if (rcnt == 0) begin
                ram_rvalid_i = 1;
                if (c_we) ram_mem[c_addr] = merge(rd_ram(c_addr), c_wdata, c_sel);
                else      ram_rdata_i = rd_ram(c_addr);
                r_out = 0;
            end else rcnt--;
        end else if (ram_req_o) begin
            if (gcnt == 0) begin
                ram_gnt_i = 1;
                c_we = ram_we_o; c_addr = ram_addr_o; c_wdata = ram_wdata_o; c_sel = ram_sel_o;
                r_out = 1; rcnt = next_rdelay() - 1; gcnt = next_gdelay();
            end else gcnt--;
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            ram_rvalid_i = 1;
        end
    endtask

    // One clock: RAM reacts, model steps on the edge, outputs checked mid-cycle.
    task automatic tick();
        ram_drive();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 0;
        cpu_rwe_i = 0; cpu_addr_i = 0; cpu_sel_i = 0; cpu_wdata_i = 0;
        model_reset();
        ram_reset();
        repeat (2) @(negedge clk);
        chk("rst_ctl", {ram_sel_o, cpu_busy_o, cpu_done_o, ram_req_o, ram_we_o}, 64'd0);
        chk("rst_rdata", cpu_rdata_o, 64'd0);
        chk("rst_ram_bus", {ram_addr_o, ram_wdata_o}, 64'd0);
        rst = 1;
    endtask

    task automatic new_req(input int c);
        cpu_rwe_i[2*c +: 2]    = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        cpu_addr_i[32*c +: 32] = 32'($urandom_range(0, 63));
        cpu_sel_i[4*c +: 4]    = 4'($urandom_range(0, 15));
        cpu_wdata_i[32*c +: 32] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0_cyc, d1_cyc;
        bit d1_seen, any_done, t2_seen;
        int order[$];
        int grants[$];
        logic [1:0] prev_busy;

        rand_mode = 0; spur_en = 0; g_delay = 0; r_delay = 1;

        // ---- read, immediate grant, rvalid one cycle later ----
        do_reset();
        ram_mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        cpu_rwe_i = 4'b0001; cpu_addr_i = {32'h0, 32'h100};
        d0_cyc = -1; d1_seen = 0;
        for (int cy = 1; cy <= 6; cy++) begin
            tick();
            if (cy == 1) chk("t1_req_addr", {31'd0, ram_req_o, ram_addr_o}, {31'd0, 1'b1, 32'h100});
            if (cy == 1 || cy == 2) chk("t1_busy", cpu_busy_o, 2'b01);
            if (cpu_done_o[0] && d0_cyc < 0) d0_cyc = cy;
            if (cpu_done_o[1]) d1_seen = 1;
            if (cpu_done_o[0]) cpu_rwe_i = 4'b0000;
        end
        chk("t1_done_cycle", d0_cyc, 3);
        chk("t1_rdata", cpu_rdata_o[31:0], 32'hDEAD_BEEF);
        chk("t1_no_done1", d1_seen, 0);

        // ---- simultaneous ch0 read and ch1 write after reset ----
        do_reset();
        cpu_rwe_i = 4'b1001; cpu_addr_i = {32'h200, 32'h104};
        cpu_sel_i = 8'hF0; cpu_wdata_i = {32'h1234_5678, 32'h0};
        t2_seen = 0;
        for (int cy = 1; cy <= 20 && order.size() < 2; cy++) begin
            tick();
            if (ram_req_o && cpu_busy_o[1] && !t2_seen) begin
                t2_seen = 1;
                chk("t2_issue2", {ram_we_o, ram_sel_o, ram_addr_o}, {1'b1, 4'hF, 32'h200});
                chk("t2_issue2_wdata", ram_wdata_o, 32'h1234_5678);
            end
            for (int c = 0; c < 2; c++) begin
                if (cpu_done_o[c]) begin
                    order.push_back(c);
                    cpu_rwe_i[2*c +: 2] = 2'b00;
                end
            end
        end
        chk("t2_done_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("t2_first", order[0], 0);
            chk("t2_second", order[1], 1);
        end

        // ---- continuous contention: grants must alternate ----
        do_reset();
        rand_mode = 1; ram_reset();
        cpu_rwe_i = 4'b0101; cpu_addr_i = {32'h500, 32'h400};
        prev_busy = 2'b00;
        for (int cy = 1; cy <= 200 && grants.size() < 6; cy++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                if (cpu_busy_o[c] && !prev_busy[c]) grants.push_back(c);
                if (cpu_done_o[c]) cpu_addr_i[32*c +: 32] = cpu_addr_i[32*c +: 32] + 32'd4;
            end
            prev_busy = cpu_busy_o;
        end
        cpu_rwe_i = 4'b0000;
        chk("t3_grant_count", grants.size(), 6);
        foreach (grants[i]) chk("t3_grant_order", grants[i], i % 2);
        for (int cy = 0; cy < 30; cy++) begin
            if (!m_act && m_dpulse == 2'b00) break;
            tick();
        end

        // ---- grant held off for 5 cycles ----
        rand_mode = 0; g_delay = 5; r_delay = 1; ram_reset();
        cpu_rwe_i = 4'b0010; cpu_addr_i = {32'h0, 32'h303};
        cpu_sel_i = 8'h05; cpu_wdata_i = {32'h0, 32'hCAFE_F00D};
        d0_cyc = -1;
        for (int cy = 1; cy <= 10; cy++) begin
            tick();
            if (cy <= 6) begin
                chk("t4_hold_ctl", {ram_req_o, ram_we_o, ram_sel_o, cpu_busy_o, cpu_done_o},
                    {1'b1, 1'b1, 4'h5, 2'b01, 2'b00});
                chk("t4_hold_bus", {ram_addr_o, ram_wdata_o}, {32'h303, 32'hCAFE_F00D});
            end
            if (cpu_done_o[0] && d0_cyc < 0) d0_cyc = cy;
            if (cpu_done_o[0]) cpu_rwe_i = 4'b0000;
        end
        chk("t4_done_cycle", d0_cyc, 8);

        // ---- reset while waiting for the response ----
        g_delay = 0; r_delay = 4; ram_reset();
        cpu_rwe_i = 4'b0001; cpu_addr_i = {32'h0, 32'h104};
        tick();
        tick();
        #2;
        rst = 0;
        #1;
        chk("t5_rst_ctl", {ram_sel_o, cpu_busy_o, cpu_done_o, ram_req_o, ram_we_o}, 64'd0);
        chk("t5_rst_rdata", cpu_rdata_o, 64'd0);
        chk("t5_rst_bus", {ram_addr_o, ram_wdata_o}, 64'd0);
        model_reset();
        r_delay = 1; ram_reset();
        cpu_rwe_i = 4'b0000;
        @(negedge clk);
        rst = 1;
        check_model();
        any_done = 0;
        for (int cy = 0; cy < 4; cy++) begin
            tick();
            if (cpu_done_o != 2'b00) any_done = 1;
        end
        chk("t5_no_stale_done", any_done, 0);
        cpu_rwe_i = 4'b0100; cpu_addr_i = {32'h208, 32'h0};
        d1_cyc = -1; d1_seen = 0;
        for (int cy = 1; cy <= 8; cy++) begin
            tick();
            if (cpu_done_o[1] && d1_cyc < 0) d1_cyc = cy;
            if (cpu_done_o[0]) d1_seen = 1;
            if (cpu_done_o[1]) cpu_rwe_i = 4'b0000;
        end
        chk("t5_fresh_done_cycle", d1_cyc, 3);
        chk("t5_no_done0", d1_seen, 0);

`ifdef MEM_ARB_STAT_EN
        // ---- statistics: ch1 waits behind one ch0 transaction ----
        do_reset();
        cpu_rwe_i = 4'b0001; cpu_addr_i = {32'h0, 32'h10};
        tick();
        cpu_rwe_i[3:2] = 2'b01; cpu_addr_i[63:32] = 32'h14;
        d1_seen = 0;
        for (int cy = 0; cy < 20 && !d1_seen; cy++) begin
            tick();
            for (int c = 0; c < 2; c++) if (cpu_done_o[c]) cpu_rwe_i[2*c +: 2] = 2'b00;
            if (cpu_done_o[1]) d1_seen = 1;
        end
        chk("t6_req_cnt", stat_req_cnt_o, {32'd1, 32'd1});
        chk("t6_wait_ch1", stat_wait_cnt_o[63:32], 32'd4);
        chk("t6_wait_ch0", stat_wait_cnt_o[31:0], 32'd1);
`endif

        // ---- random traffic ----
        do_reset();
        rand_mode = 1; spur_en = 1; ram_reset();
        for (int cy = 0; cy < 3000; cy++) begin
            for (int c = 0; c < 2; c++) begin
                logic [1:0] f;
                f = cpu_rwe_i[2*c +: 2];
                if (m_dpulse[c]) begin
                    if ($urandom_range(0, 1) == 0) new_req(c);
                    else cpu_rwe_i[2*c +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                end else if (m_act && m_own == c) begin
                    if ($urandom_range(0, 3) == 0) begin
                        cpu_rwe_i[2*c +: 2]     = 2'($urandom_range(0, 3));
                        cpu_addr_i[32*c +: 32]  = $urandom;
                        cpu_sel_i[4*c +: 4]     = 4'($urandom_range(0, 15));
                        cpu_wdata_i[32*c +: 32] = $urandom;
                    end
                end else if (!(f == 2'b01 || f == 2'b10)) begin
                    if ($urandom_range(0, 2) == 0) new_req(c);
                end
            end
            tick();
        end
        cpu_rwe_i = 4'b0000;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sits directly downstream of the CPU top. Consumes its dual-channel memory request bus (channel 1 = I-cache in the upper slices, channel 0 = D-cache in the lower slices) and serialises both channels onto one single-port word memory with a req/gnt/rvalid handshake. One transaction is outstanding at a time. Round-robin arbitration applies when both channels request together. Completion is returned to the owning channel as a busy/done handshake.

Parameters:
ADDR_W, 32, address width per channel and on the RAM side
DATA_W, 32, data width per channel and on the RAM side

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
cpu_rwe_i  in  4  per-channel rw flag; [3:2] ch1, [1:0] ch0; 2'b01 read, 2'b10 write, 2'b00/2'b11 idle
cpu_addr_i  in  2*ADDR_W  request address; [63:32] ch1, [31:0] ch0
cpu_sel_i  in  8  byte write mask; [7:4] ch1, [3:0] ch0
cpu_wdata_i  in  2*DATA_W  write data, same slicing
cpu_rdata_o  out  2*DATA_W  read data per channel, same slicing
cpu_busy_o  out  2  channel request accepted, not yet done; [1] ch1
cpu_done_o  out  2  one-cycle completion pulse per channel
ram_req_o  out  1  RAM request valid
ram_we_o  out  1  1 = write, 0 = read
ram_addr_o  out  ADDR_W  RAM address
ram_wdata_o  out  DATA_W  RAM write data
ram_sel_o  out  4  RAM byte mask (all ones on reads)
ram_gnt_i  in  1  RAM accepts request this cycle
ram_rvalid_i  in  1  RAM response; exactly one per accepted request, reads and writes
ram_rdata_i  in  DATA_W  RAM read data, valid with ram_rvalid_i

Behaviour:
- Reset (rst=0, async): every output is 0; FSM goes to IDLE; last_grant=1, so ch0 wins the first tie.
- Channel eligible when its flag is 01/10, its busy is 0 and its done is 0 this cycle.
- FSM IDLE -> ISSUE -> WAIT_RESP -> RESP -> IDLE.
- IDLE: if any channel is eligible, grant it and go to ISSUE. The same edge latches addr, wdata, sel, we and owner, and sets busy[owner]=1.
- Tie in IDLE: grant the channel != last_grant. last_grant updates on each grant.
- ISSUE: ram_req_o=1 with latched fields held stable. On a ram_gnt_i=1 sample, drop req and go to WAIT_RESP.
- WAIT_RESP: ram_req_o=0. On ram_rvalid_i=1, capture ram_rdata_i into rdata[owner] (reads only) and go to RESP.
- ram_rvalid_i outside WAIT_RESP is ignored. The RAM must not assert it in the grant cycle.
- RESP: done[owner]=1 for exactly one cycle, busy[owner]=0. Next state is IDLE.
- cpu_rdata_o slice holds its value until that channel's next read completes. Write completion leaves the slice unchanged.
- Minimum latency (gnt immediate, rvalid one cycle later): flag seen at cycle 0, ram_req_o at 1, rvalid at 2, done at 3.
- The requester must drop or change its flag by the cycle after done. The done-cycle exclusion prevents re-accepting the same request.
- The other channel's flag is sampled only in IDLE. A channel waiting while the other is served just waits; its busy stays 0 until granted.
- Write with sel=0000 is still issued (RAM no-op) and completes normally.
- ram_sel_o=1111 on reads. Address is passed unmodified, including low bits.
- Flag change while busy is ignored; the latched request completes.
- Reset mid-transaction abandons it; no done is produced.

Optional Feature:
MEM_ARB_STAT_EN.
- Defined: adds outputs stat_req_cnt_o[63:0] ({ch1,ch0}, 32-bit each) and stat_wait_cnt_o[63:0].
- Request counter: +1 per grant.
- Wait counter: +1 per cycle a channel has a valid flag but is neither busy nor done.
- Counters wrap modulo 2^32 and clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines: rw flag encodings (RW_IDLE 2'b00, RW_READ 2'b01, RW_WRITE 2'b10) and FSM state encodings (IDLE, ISSUE, WAIT_RESP, RESP, 2-bit).
- One sub-module, mem_arb_rr: combinational 2-way round-robin picker.
  - Inputs: eligible[1:0], last_grant.
  - Outputs: grant_valid, grant_id.

Test Plan:
- ch0 read addr 0x100, RAM gnt immediate, rvalid one cycle later with 0xDEADBEEF. Expect done[0] at cycle 3, cpu_rdata_o[31:0]=0xDEADBEEF, busy[0] high cycles 1-2, done[1] never.
- ch0 read and ch1 write (0x200, 0x12345678, sel 1111) both at cycle 0 after reset. Expect ch0 served first, then ch1. ram_we_o=1, addr 0x200 on the second issue; one done per channel, in order.
- Both channels re-request continuously for 6 transactions. Expect grants alternating 0,1,0,1,0,1 and no channel starved.
- ram_gnt_i held low 5 cycles. Expect ram_req_o and fields stable throughout, busy held, no done until gnt and rvalid.
- Assert rst=0 during WAIT_RESP. Expect all outputs 0 immediately; no done after release; a fresh ch1 request then completes normally.
- With MEM_ARB_STAT_EN: ch1 waits 4 cycles behind a ch0 transaction. Expect stat_wait_cnt ch1=4, stat_req_cnt = {1,1}.
